// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the fetch and decode pipeline latches: resolves
// load-use hazards, memory-busy stalls and taken-jump flushes into latch enables/clears.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int LU_CYCLES    = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       dec_selA,
    input  logic [4:0]       dec_selB,
    input  logic             dec_imm_en,
    input  logic             ex_lam_new,
    input  logic             ex_lam_rw,
    input  logic [4:0]       ex_lam_sel_out,
    input  logic             mem_busy,
    input  logic             jmp_taken,
    output logic             fetch_en,
    output logic             fetch_flush,
    output logic             dec_en,
    output logic             dec_flush,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2,
        MEM_WAIT = 2'd3
    } state_t;

    localparam int MAX_C = (FLUSH_CYCLES > LU_CYCLES) ? FLUSH_CYCLES : LU_CYCLES;
    localparam int CW    = $clog2(MAX_C) + 1;
    localparam logic [CW-1:0] FLUSH_INIT = CW'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] LU_INIT    = CW'(LU_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic             lu;

    // Load in execute whose destination feeds a GPR source of the decoding instruction.
    assign lu = ex_lam_new & ~ex_lam_rw & (ex_lam_sel_out != 5'd0) &
                ((~dec_selA[5] & (dec_selA[4:0] == ex_lam_sel_out)) |
                 (~dec_imm_en & (dec_selB == ex_lam_sel_out)));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fetch_en    = 1'b1;
        dec_en      = 1'b1;
        fetch_flush = 1'b0;
        dec_flush   = 1'b0;

        if (jmp_taken) begin
            fetch_flush = 1'b1;
            dec_flush   = 1'b1;
            cnt_d       = FLUSH_INIT;
            state_d     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (mem_busy) begin
            fetch_en = 1'b0;
            dec_en   = 1'b0;
            state_d  = MEM_WAIT;
        end else begin
            case (state_q)
                LU_STALL: begin
                    fetch_en  = 1'b0;
                    dec_flush = 1'b1;
                    cnt_d     = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = RUN;
                end
                FLUSH: begin
                    fetch_flush = 1'b1;
                    dec_flush   = 1'b1;
                    cnt_d       = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = RUN;
                end
                default: begin
                    // RUN, and MEM_WAIT once memory frees up, behave identically.
                    state_d = RUN;
                    if (lu) begin
                        fetch_en  = 1'b0;
                        dec_flush = 1'b1;
                        cnt_d     = LU_INIT;
                        state_d   = (LU_CYCLES > 1) ? LU_STALL : RUN;
                    end
                end
            endcase
        end

        if (!reset) begin
            fetch_en    = 1'b0;
            dec_en      = 1'b0;
            fetch_flush = 1'b1;
            dec_flush   = 1'b1;
        end

        stall_cycles_d = stall_cycles_q;
        if (!fetch_en && (stall_cycles_q != {CNT_W{1'b1}}))
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= RUN;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign state_o      = state_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: dut (FLUSH_CYCLES=3, LU_CYCLES=2) and dut1 (1/1, 3-bit counter)
// share all inputs; outputs are compared as {fetch_en,fetch_flush,dec_en,dec_flush}.
module tb_pipe_hazard_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  dec_selA;
    logic [4:0]  dec_selB;
    logic        dec_imm_en, ex_lam_new, ex_lam_rw, mem_busy, jmp_taken;
    logic [4:0]  ex_lam_sel_out;

    logic        fe, ff, de, df;
    logic [1:0]  st;
    logic [15:0] sc;
    logic        fe1, ff1, de1, df1;
    logic [1:0]  st1;
    logic [2:0]  sc1;
    wire  [3:0]  outs  = {fe, ff, de, df};
    wire  [3:0]  outs1 = {fe1, ff1, de1, df1};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .LU_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .dec_selA(dec_selA), .dec_selB(dec_selB),
        .dec_imm_en(dec_imm_en), .ex_lam_new(ex_lam_new), .ex_lam_rw(ex_lam_rw),
        .ex_lam_sel_out(ex_lam_sel_out), .mem_busy(mem_busy), .jmp_taken(jmp_taken),
        .fetch_en(fe), .fetch_flush(ff), .dec_en(de), .dec_flush(df),
        .state_o(st), .stall_cycles(sc));

    pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .LU_CYCLES(1), .CNT_W(3)) dut1 (
        .clk(clk), .reset(reset), .dec_selA(dec_selA), .dec_selB(dec_selB),
        .dec_imm_en(dec_imm_en), .ex_lam_new(ex_lam_new), .ex_lam_rw(ex_lam_rw),
        .ex_lam_sel_out(ex_lam_sel_out), .mem_busy(mem_busy), .jmp_taken(jmp_taken),
        .fetch_en(fe1), .fetch_flush(ff1), .dec_en(de1), .dec_flush(df1),
        .state_o(st1), .stall_cycles(sc1));

    localparam logic [3:0] O_RUN   = 4'b1010;
    localparam logic [3:0] O_LU    = 4'b0011;
    localparam logic [3:0] O_FLUSH = 4'b1111;
    localparam logic [3:0] O_MEM   = 4'b0000;
    localparam logic [3:0] O_RST   = 4'b0101;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        dec_selA = 6'd0; dec_selB = 5'd0; dec_imm_en = 1'b0;
        ex_lam_new = 1'b0; ex_lam_rw = 1'b0; ex_lam_sel_out = 5'd0;
        mem_busy = 1'b0; jmp_taken = 1'b0;
    endtask

    task automatic set_load_hazard();
        ex_lam_new = 1'b1; ex_lam_rw = 1'b0; ex_lam_sel_out = 5'd5; dec_selA = 6'd5;
    endtask

    task automatic do_reset();
        clr_inputs();
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (outs !== O_RUN || st !== 2'd0 || sc !== 16'd0) begin errors++;
            $display("FAIL reset_release outs=%b st=%0d sc=%0d exp outs=%b st=0 sc=0", outs, st, sc, O_RUN); end
        set_load_hazard();
        #1;
        checks++; if (outs !== O_LU) begin errors++;
            $display("FAIL rst_lu_entry outs=%b exp %b", outs, O_LU); end
        tick();
        checks++; if (st !== 2'd1) begin errors++;
            $display("FAIL rst_in_lu_stall st=%0d exp 1", st); end
        reset = 1'b0;
        #1;
        checks++; if (outs !== O_RST || st !== 2'd0 || sc !== 16'd0) begin errors++;
            $display("FAIL reset_mid_stall outs=%b st=%0d sc=%0d exp outs=%b st=0 sc=0", outs, st, sc, O_RST); end
        tick();
        clr_inputs();
        reset = 1'b1;
        #1;
        checks++; if (outs !== O_RUN || st !== 2'd0 || sc !== 16'd0) begin errors++;
            $display("FAIL reset_after outs=%b st=%0d sc=%0d exp outs=%b st=0 sc=0", outs, st, sc, O_RUN); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_hazard();
        #1;
        checks++; if (outs !== O_LU || outs1 !== O_LU) begin errors++;
            $display("FAIL lu_cycle1 outs=%b outs1=%b exp %b", outs, outs1, O_LU); end
        tick();
        ex_lam_new = 1'b0;
        #1;
        checks++; if (st !== 2'd1 || outs !== O_LU) begin errors++;
            $display("FAIL lu_cycle2 st=%0d outs=%b exp st=1 outs=%b", st, outs, O_LU); end
        checks++; if (st1 !== 2'd0 || outs1 !== O_RUN) begin errors++;
            $display("FAIL lu1_single st1=%0d outs1=%b exp st1=0 outs1=%b", st1, outs1, O_RUN); end
        tick();
        checks++; if (st !== 2'd0 || outs !== O_RUN || sc !== 16'd2 || sc1 !== 3'd1) begin errors++;
            $display("FAIL lu_done st=%0d outs=%b sc=%0d sc1=%0d exp st=0 outs=%b sc=2 sc1=1", st, outs, sc, sc1, O_RUN); end
    endtask

    task automatic test_no_hazard();
        clr_inputs();
        ex_lam_new = 1'b1; ex_lam_sel_out = 5'd5;
        dec_selA = 6'h25; dec_imm_en = 1'b1; dec_selB = 5'd5;
        #1;
        checks++; if (outs !== O_RUN) begin errors++;
            $display("FAIL nohz_nongpr outs=%b exp %b", outs, O_RUN); end
        ex_lam_sel_out = 5'd0; dec_selA = 6'd0; dec_selB = 5'd0; dec_imm_en = 1'b0;
        #1;
        checks++; if (outs !== O_RUN) begin errors++;
            $display("FAIL nohz_r0 outs=%b exp %b", outs, O_RUN); end
        ex_lam_sel_out = 5'd9; dec_selB = 5'd9; ex_lam_rw = 1'b1;
        #1;
        checks++; if (outs !== O_RUN) begin errors++;
            $display("FAIL nohz_store outs=%b exp %b", outs, O_RUN); end
        ex_lam_rw = 1'b0;
        #1;
        checks++; if (outs !== O_LU) begin errors++;
            $display("FAIL hz_selB outs=%b exp %b", outs, O_LU); end
        tick();
        clr_inputs();
        tick();
        checks++; if (st !== 2'd0 || outs !== O_RUN) begin errors++;
            $display("FAIL hz_selB_done st=%0d outs=%b exp st=0 outs=%b", st, outs, O_RUN); end
    endtask

    task automatic test_jump();
        logic [15:0] sc0;
        sc0 = sc;
        jmp_taken = 1'b1;
        #1;
        checks++; if (outs !== O_FLUSH || st !== 2'd0) begin errors++;
            $display("FAIL jmp_c1 outs=%b st=%0d exp %b st=0", outs, st, O_FLUSH); end
        tick();
        jmp_taken = 1'b0;
        #1;
        checks++; if (outs !== O_FLUSH || st !== 2'd2) begin errors++;
            $display("FAIL jmp_c2 outs=%b st=%0d exp %b st=2", outs, st, O_FLUSH); end
        checks++; if (outs1 !== O_RUN || st1 !== 2'd0) begin errors++;
            $display("FAIL jmp1_single outs1=%b st1=%0d exp %b st1=0", outs1, st1, O_RUN); end
        tick();
        checks++; if (outs !== O_FLUSH || st !== 2'd2) begin errors++;
            $display("FAIL jmp_c3 outs=%b st=%0d exp %b st=2", outs, st, O_FLUSH); end
        tick();
        checks++; if (outs !== O_RUN || st !== 2'd0 || sc !== sc0) begin errors++;
            $display("FAIL jmp_done outs=%b st=%0d sc=%0d exp %b st=0 sc=%0d", outs, st, sc, O_RUN, sc0); end
    endtask

    task automatic test_mem_busy_lu();
        do_reset();
        set_load_hazard();
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (outs !== O_MEM || outs1 !== O_MEM) begin errors++;
                $display("FAIL mem_c%0d outs=%b outs1=%b exp %b", i, outs, outs1, O_MEM); end
            tick();
        end
        mem_busy = 1'b0;
        #1;
        checks++; if (st1 !== 2'd3 || outs1 !== O_LU || outs !== O_LU) begin errors++;
            $display("FAIL mem_lu st1=%0d outs1=%b outs=%b exp st1=3 %b", st1, outs1, outs, O_LU); end
        tick();
        ex_lam_new = 1'b0;
        #1;
        checks++; if (st1 !== 2'd0 || outs1 !== O_RUN || sc1 !== 3'd5) begin errors++;
            $display("FAIL mem_done1 st1=%0d outs1=%b sc1=%0d exp st1=0 %b sc1=5", st1, outs1, sc1, O_RUN); end
        checks++; if (st !== 2'd1 || outs !== O_LU) begin errors++;
            $display("FAIL mem_lu2 st=%0d outs=%b exp st=1 %b", st, outs, O_LU); end
        tick();
        checks++; if (st !== 2'd0 || sc !== 16'd6) begin errors++;
            $display("FAIL mem_done st=%0d sc=%0d exp st=0 sc=6", st, sc); end
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        mem_busy = 1'b0;
        tick();
        checks++; if (sc1 !== 3'd7 || sc !== 16'd10) begin errors++;
            $display("FAIL stall_sat sc1=%0d sc=%0d exp sc1=7 sc=10", sc1, sc); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_load_hazard();
        tick();
        checks++; if (st !== 2'd1) begin errors++;
            $display("FAIL b2b_lu st=%0d exp 1", st); end
        jmp_taken = 1'b1; mem_busy = 1'b1;
        #1;
        checks++; if (outs !== O_FLUSH || outs1 !== O_FLUSH) begin errors++;
            $display("FAIL b2b_jmp outs=%b outs1=%b exp %b", outs, outs1, O_FLUSH); end
        tick();
        clr_inputs();
        #1;
        checks++; if (st !== 2'd2 || outs !== O_FLUSH || st1 !== 2'd0 || outs1 !== O_RUN) begin errors++;
            $display("FAIL b2b_flush st=%0d outs=%b st1=%0d outs1=%b exp st=2 st1=0", st, outs, st1, outs1); end
        tick(); tick();
        checks++; if (st !== 2'd0 || outs !== O_RUN || sc !== 16'd1) begin errors++;
            $display("FAIL b2b_done st=%0d outs=%b sc=%0d exp st=0 %b sc=1", st, outs, sc, O_RUN); end
    endtask

    initial begin
        clr_inputs();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_jump();
        test_mem_busy_lu();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
